// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one uart_tx among NUM_CH byte sources.
// Optional inter-packet idle gap is enabled by defining UART_ARB_GAP_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int HOLD_TIMEOUT = 1023,
    parameter int GAP_CYCLES   = 434
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*8-1:0]       req_data,
    input  logic [NUM_CH-1:0]         req_last,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_done,
    output logic [$clog2(NUM_CH)-1:0] grant_ch,
    output logic                      busy
);
    localparam int CW = $clog2(NUM_CH);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);

    generate
        if (NUM_CH < 2 || NUM_CH > 8 || HOLD_TIMEOUT < 1 || GAP_CYCLES < 1) begin : g_bad_param
            $error("uart_tx_arbiter: illegal parameter value");
        end
    endgenerate

    // Handshake: a byte moves on every rising edge where req_valid[i] and req_ready[i] are
    // both high; req_ready is combinational and never depends on the same channel's data.
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
`ifdef UART_ARB_GAP_EN
        GAP,
`endif
        HOLD
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   rr_ptr;
    logic [HW-1:0]   hold_cnt;
    logic            last_r;
    logic [CW-1:0]   winner;
    logic            found;
    logic            accept;
    logic [CW-1:0]   acc_ch;
    logic            release_grant;
`ifdef UART_ARB_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]   gap_cnt;
`endif

    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CW'(s);
    endfunction

    // Descending scan so the smallest offset from rr_ptr+1 is the one that sticks.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k)]) begin
                winner = wrap_idx(rr_ptr, k);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        req_ready     = '0;
        accept        = 1'b0;
        acc_ch        = grant_ch;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    acc_ch            = winner;
                    next_state        = SEND;
                end
            end
            SEND: next_state = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (last_r) begin
                        release_grant = 1'b1;
`ifdef UART_ARB_GAP_EN
                        next_state    = GAP;
`else
                        next_state    = IDLE;
`endif
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_valid[grant_ch]) begin
                    req_ready[grant_ch] = 1'b1;
                    accept              = 1'b1;
                    next_state          = SEND;
                end else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                    release_grant = 1'b1;
                    next_state    = IDLE;
                end
            end
`ifdef UART_ARB_GAP_EN
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    assign tx_start = (state == SEND);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            last_r   <= 1'b0;
            grant_ch <= '0;
            rr_ptr   <= CW'(NUM_CH - 1);
            hold_cnt <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                tx_data  <= req_data[{acc_ch, 3'b000} +: 8];
                last_r   <= req_last[acc_ch];
                grant_ch <= acc_ch;
            end
            if (release_grant) rr_ptr <= grant_ch;
            // Counts consecutive empty HOLD cycles; zero whenever HOLD is entered.
            if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;
        end
    end

`ifdef UART_ARB_GAP_EN
    always_ff @(posedge clk) begin
        if (!rstn)              gap_cnt <= '0;
        else if (state == GAP)  gap_cnt <= gap_cnt + 1'b1;
        else                    gap_cnt <= '0;
    end
`endif

endmodule
